// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU execution controller.
package cpu_pkg;

   // Button FSM states; encoding is visible on the STATE output.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StPress    = 2'd1,
      StLongHeld = 2'd2
   } btn_state_t;

   localparam logic MODE_STEP = 1'b0;
   localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter. The debounced level only
// follows the synchronized input after it has held a new value for DEBOUNCE cycles.
module debounce #(
   parameter int unsigned DEBOUNCE = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   localparam logic [31:0] DbLast = 32'(DEBOUNCE - 1);

   logic        sync0_q, sync1_q;
   logic        level_q, level_d;
   logic [31:0] cnt_q, cnt_d;

   // Count while the synchronized input disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync1_q != level_q) begin
         if (cnt_q == DbLast) begin
            level_d = sync1_q;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   // Synchronizer, counter and accepted level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync0_q <= d_i;
         sync1_q <= sync0_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q_o = level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: turns a debounced push button and a run/step mode switch into
// one-cycle advance (cpu_en_o) and reset (cpu_reset_o) pulses for the CPU core.
module cpu_step_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned PERIOD   = 50_000_000,
   parameter int unsigned DEBOUNCE = 1_000_000,
   parameter int unsigned LONG     = 100_000_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       button_i,
   input  logic       mode_i,
   input  logic       halt_i,
   output logic       cpu_en_o,
   output logic       cpu_reset_o,
   output logic       tick_o,
   output logic [1:0] state_o
);

   localparam logic [31:0] PeriodLast = 32'(PERIOD - 1);
   localparam logic [31:0] LongLast   = 32'(LONG - 1);

   logic        btn_db;
   logic        mode_s0_q, mode_s1_q;
   logic        mode_change;

   btn_state_t  state_q, state_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] period_q, period_d;
   logic        step_req;
   logic        adv;
   logic        cpu_en_q, cpu_en_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        tick_q, tick_d;

   debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_btn_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (button_i),
      .q_o    (btn_db)
   );

   // Plain 2-flop synchronizer for the mode switch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_s0_q <= 1'b0;
         mode_s1_q <= 1'b0;
      end else begin
         mode_s0_q <= mode_i;
         mode_s1_q <= mode_s0_q;
      end
   end

   // The synced mode flips on the next edge; clear the period counter on that same edge.
   assign mode_change = mode_s0_q ^ mode_s1_q;

   // Button FSM: short press requests a step, long press pulses CPU reset.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      step_req    = 1'b0;
      cpu_reset_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            hold_d = '0;
            if (btn_db) begin
               state_d = StPress;
            end
         end
         StPress: begin
            if (hold_q == LongLast) begin
               state_d     = StLongHeld;
               cpu_reset_d = 1'b1;
            end else if (!btn_db) begin
               state_d  = StIdle;
               step_req = 1'b1;
            end else begin
               hold_d = hold_q + 32'd1;
            end
         end
         StLongHeld: begin
            if (!btn_db) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Advance decision, free-running period counter and heartbeat.
   always_comb begin
      if (cpu_reset_d || mode_change || (period_q == PeriodLast)) begin
         period_d = '0;
      end else begin
         period_d = period_q + 32'd1;
      end

      if (mode_s1_q == MODE_RUN) begin
         adv = (period_q == PeriodLast) && !halt_i;
      end else begin
         adv = step_req && !halt_i;
      end

      // Reset pulse always wins over an advance.
      cpu_en_d = adv && !cpu_reset_d;
      tick_d   = tick_q ^ cpu_en_d;
   end

   // State and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         period_q    <= '0;
         cpu_en_q    <= 1'b0;
         cpu_reset_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         period_q    <= period_d;
         cpu_en_q    <= cpu_en_d;
         cpu_reset_q <= cpu_reset_d;
         tick_q      <= tick_d;
      end
   end

   assign cpu_en_o    = cpu_en_q;
   assign cpu_reset_o = cpu_reset_q;
   assign tick_o      = tick_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected pulse cycles are queued when stimulus is
// applied and popped when the DUT emits a pulse.
module tb_cpu_step_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       button;
   logic       mode;
   logic       halt;
   logic       cpu_en_o;
   logic       cpu_reset_o;
   logic       tick_o;
   logic [1:0] state_o;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int exp_en_q[$];
   int exp_rst_q[$];
   logic tick_exp = 1'b0;

   cpu_step_ctrl #(
      .PERIOD   (4),
      .DEBOUNCE (3),
      .LONG     (10)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .button_i    (button),
      .mode_i      (mode),
      .halt_i      (halt),
      .cpu_en_o    (cpu_en_o),
      .cpu_reset_o (cpu_reset_o),
      .tick_o      (tick_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Pulse monitor: every observed pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!rst_n) tick_exp = 1'b0;
      if (cpu_en_o) begin
         if (exp_en_q.size() == 0) check("en_unexpected", cyc, -1);
         else check("en_cycle", cyc, exp_en_q.pop_front());
         tick_exp = ~tick_exp;
         check("tick", int'(tick_o), int'(tick_exp));
      end
      if (cpu_reset_o) begin
         if (exp_rst_q.size() == 0) check("rst_unexpected", cyc, -1);
         else check("rst_cycle", cyc, exp_rst_q.pop_front());
      end
   end

   initial begin
      int r, k, m;
      rst_n  = 1'b0;
      button = 1'b0;
      mode   = 1'b1;
      halt   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_en", int'(cpu_en_o), 0);
      check("rst_reset", int'(cpu_reset_o), 0);
      check("rst_tick", int'(tick_o), 0);
      check("rst_state", int'(state_o), 0);

      // Run mode: synced mode change clears the counter 2 edges after release,
      // first pulse PERIOD edges later, then every PERIOD.
      rst_n = 1'b1;
      r = cyc;
      for (int i = 0; i < 3; i++) exp_en_q.push_back(r + 6 + 4 * i);
      wait_until(r + 15);
      mode = 1'b0;
      repeat (4) @(negedge clk);

      // Short press: rise accepted at +5, PRESS at +6; fall accepted 5 edges after raw
      // fall, pulse one edge later.
      k = cyc;
      button = 1'b1;
      repeat (6) @(negedge clk);
      check("press_state", int'(state_o), 1);
      button = 1'b0;
      exp_en_q.push_back(k + 12);
      repeat (6) @(negedge clk);
      check("release_state", int'(state_o), 0);
      repeat (4) @(negedge clk);

      // Glitchy button never survives the stability filter.
      for (int i = 0; i < 10; i++) begin
         button = 1'b1;
         @(negedge clk);
         button = 1'b0;
         @(negedge clk);
         check("glitch_state", int'(state_o), 0);
      end
      repeat (6) @(negedge clk);
      check("glitch_after", int'(state_o), 0);

      // Long hold: PRESS at +6, LONG cycles in PRESS, reset pulse at +16.
      k = cyc;
      button = 1'b1;
      exp_rst_q.push_back(k + 16);
      repeat (17) @(negedge clk);
      check("long_state", int'(state_o), 2);
      repeat (3) @(negedge clk);
      button = 1'b0;
      repeat (7) @(negedge clk);
      check("long_release", int'(state_o), 0);

      // Halted step press: request dropped.
      halt = 1'b1;
      button = 1'b1;
      repeat (6) @(negedge clk);
      button = 1'b0;
      repeat (8) @(negedge clk);
      check("halt_step_state", int'(state_o), 0);

      // Halted run: counter keeps running, pulses resume on its phase.
      m = cyc;
      mode = 1'b1;
      wait_until(m + 12);
      halt = 1'b0;
      exp_en_q.push_back(m + 14);
      exp_en_q.push_back(m + 18);
      wait_until(m + 19);
      mode = 1'b0;
      repeat (6) @(negedge clk);

      // Asynchronous reset in the middle of a press.
      button = 1'b1;
      repeat (8) @(negedge clk);
      check("pre_reset_state", int'(state_o), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_state", int'(state_o), 0);
      check("async_en", int'(cpu_en_o), 0);
      check("async_reset", int'(cpu_reset_o), 0);
      check("async_tick", int'(tick_o), 0);
      button = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("post_reset_state", int'(state_o), 0);

      check("en_left", exp_en_q.size(), 0);
      check("rst_left", exp_rst_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
